// File: rtl/period_meter.sv
// period_meter: measures period and high time of an asynchronous square wave
// in clk_in cycles. A rise on the synchronised input closes one measurement
// and starts the next. valid pulses for one cycle when period/high_time update.
// timeout flags a missing rising edge for MAX cycles.
//
// Interface semantics: there is no backpressure. valid is a one-cycle strobe.
// period/high_time are stable from the valid cycle until the next valid, a
// clear or a reset. busy mirrors the FSM state (1 = MEASURE), so the state is
// observable directly at the port.
module period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2    // must be >= 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   rise;
  logic                   fall;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       hcap;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_prev;
  assign fall   = ~s_sync & s_prev;

  // busy is a decode of the registered state, so it stays glitch-free.
  assign busy   = (state == MEASURE);

  // Synchroniser chain plus one edge-history flop. clear leaves this
  // history alone, so a level that is already high is not seen as a new rise.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev <= s_sync;
    end
  end

  // Measurement FSM: counters, captured results and status flags.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hcap      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else if (clear) begin
      // clear wins over a rise detected in the same cycle.
      state     <= IDLE;
      cnt       <= '0;
      hcap      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          // The first rise only starts a measurement. A fall is ignored.
          if (rise) begin
            cnt   <= ONE;
            hcap  <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // cnt equals the number of cycles since the previous rise.
            period    <= cnt;
            high_time <= hcap;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            cnt       <= ONE;
            hcap      <= '0;
          end else if (fall) begin
            // cnt equals the number of cycles the input was high.
            // Saturate so a fall exactly at MAX cannot wrap the counter.
            hcap <= cnt;
            cnt  <= (cnt == MAX) ? MAX : cnt + ONE;
          end else if (cnt == MAX) begin
            // No rise within MAX cycles: give up. Keep the last results.
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed testbench for period_meter (WIDTH=8 so MAX=255 is reachable).
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int W = 8;

  logic         clk_in;
  logic         reset;
  logic         sig_in;
  logic         clear;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_gap = 0;
  int last_v  = -1;

  // expected {period, high_time} for each coming valid pulse
  logic [2*W-1:0] exp_q[$];

  period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .sig_in    (sig_in),
    .clear     (clear),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_in = 1'b0;
    forever #1 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Every valid cycle must match the head of exp_q. Optionally the spacing is checked too.
  always @(negedge clk_in) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", valid, 0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("period", period, e[2*W-1:W]);
        check("high_time", high_time, e[W-1:0]);
      end
      if (exp_gap != 0 && last_v >= 0) check("valid_gap", cyc - last_v, exp_gap);
      last_v = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (h) @(negedge clk_in);
      sig_in = 1'b0;
      repeat (p - h) @(negedge clk_in);
    end
  endtask

  task automatic expect_meas(input int p, input int h);
    exp_q.push_back({W'(p), W'(h)});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk_in);
    clear = 1'b0;
  endtask

  task automatic set_gap(input int g);
    exp_gap = g;
    last_v  = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    reset  = 1'b1;
    sig_in = 1'b0;
    clear  = 1'b0;

    // reset state
    #50;
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    #50;
    @(negedge clk_in);
    reset = 1'b0;
    idle(3);

    // steady waveform: period 10, high 3, five rises -> four results
    set_gap(10);
    repeat (4) expect_meas(10, 3);
    wave(10, 3, 5);
    check("steady_pending", exp_q.size(), 0);
    check("steady_busy", busy, 1);
    check("steady_timeout", timeout, 0);
    set_gap(0);

    // input stays low -> timeout, results held
    waited = 0;
    while (!timeout && waited < 400) begin
      @(negedge clk_in);
      waited++;
    end
    check("lowhold_timeout", timeout, 1);
    check("lowhold_busy", busy, 0);
    check("lowhold_period", period, 10);
    check("lowhold_high", high_time, 3);

    // arming only: one rise, then held high
    sig_in = 1'b1;
    idle(20);
    check("arm_busy", busy, 1);
    check("arm_pending", exp_q.size(), 0);
    idle(237);
    check("arm_busy_257", busy, 1);
    idle(1);
    check("arm_busy_258", busy, 0);
    check("arm_timeout", timeout, 1);
    check("arm_period_kept", period, 10);
    check("arm_high_kept", high_time, 3);

    // timeout recovery: two rises 40 apart, high 20
    sig_in = 1'b0;
    idle(5);
    sig_in = 1'b1;
    idle(20);
    check("rec_timeout_armed", timeout, 1);
    check("rec_busy_armed", busy, 1);
    sig_in = 1'b0;
    idle(20);
    expect_meas(40, 20);
    sig_in = 1'b1;
    idle(5);
    check("rec_timeout_cleared", timeout, 0);
    check("rec_pending", exp_q.size(), 0);
    idle(15);
    sig_in = 1'b0;
    idle(10);

    // clear collides with a rise detected in MEASURE
    sig_in = 1'b1;
    idle(2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("clr_period", period, 0);
    check("clr_high", high_time, 0);
    check("clr_busy", busy, 0);
    check("clr_timeout", timeout, 0);
    idle(3);
    check("clr_no_rearm", busy, 0);
    sig_in = 1'b0;
    idle(5);
    expect_meas(7, 3);
    wave(7, 3, 2);

    // rise right after the wave closes a third period of 7
    expect_meas(7, 3);
    sig_in = 1'b1;
    idle(6);
    check("clr_pending", exp_q.size(), 0);
    check("pre_rst_period", period, 7);

    // asynchronous reset between clock edges, 4 cycles after the rise
    #0.5;
    reset = 1'b1;
    #0.2;
    check("arst_period", period, 0);
    check("arst_high", high_time, 0);
    check("arst_valid", valid, 0);
    check("arst_timeout", timeout, 0);
    check("arst_busy", busy, 0);
    @(negedge clk_in);
    sig_in = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    expect_meas(12, 5);
    wave(12, 5, 2);
    check("arst_pending", exp_q.size(), 0);

    // extreme: period 2, high 1
    pulse_clear();
    set_gap(2);
    repeat (2) expect_meas(2, 1);
    wave(2, 1, 3);
    idle(4);
    check("min_pending", exp_q.size(), 0);
    set_gap(0);

    // extreme: period 255 = MAX, no timeout
    pulse_clear();
    expect_meas(255, 100);
    wave(255, 100, 2);
    check("max_pending", exp_q.size(), 0);
    check("max_timeout", timeout, 0);
    check("max_busy", busy, 1);

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures an incoming square-wave signal in clk_in cycles; the receiving counterpart of freq_divider, which generates such signals.
- Reports period and high time of each complete cycle of sig_in, with a one-cycle valid strobe.
- Sits between slow external or divided signals (button lines, divider outputs) and display/compare logic.
- Flags loss of signal with a timeout.

Parameters:
- WIDTH, 16, width of period/high_time counters and outputs; max measurable count MAX = 2^WIDTH-1.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchroniser (legal >= 2).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal to be measured.
- clear  input  1  synchronous clear: abort the measurement and return to IDLE.
- period  output  WIDTH  clk_in cycles between the last two rising edges of sig_in.
- high_time  output  WIDTH  clk_in cycles sig_in was high within that period.
- valid  output  1  single-cycle pulse; period/high_time updated this cycle.
- timeout  output  1  level; no rising edge for MAX cycles.
- busy  output  1  high while in MEASURE state.

Behaviour:
- Reset (async, while reset=1):
  - period=0, high_time=0, valid=0, timeout=0, busy=0.
  - Synchroniser flops and edge-history flop = 0.
  - cnt=0, hcap=0, state=IDLE.
- Synchroniser:
  - sig_in passes through a SYNC_STAGES-deep chain to give s_sync; s_prev is s_sync delayed one cycle.
  - rise = s_sync & ~s_prev; fall = ~s_sync & s_prev.
- Latency: valid rises SYNC_STAGES clk_in edges after the edge that first samples sig_in high. This is 2 edges with the default.
- States: IDLE, MEASURE. busy = (state==MEASURE).
- IDLE:
  - fall is ignored.
  - On rise: cnt<=1, hcap<=0, go to MEASURE. No valid on this first edge.
- MEASURE, on a cycle with rise:
  - period<=cnt, high_time<=hcap, valid<=1, timeout<=0.
  - cnt<=1, hcap<=0, stay in MEASURE.
- MEASURE, on a cycle with fall: hcap<=cnt; cnt<=cnt+1.
- MEASURE, on any other cycle:
  - If cnt==MAX: state<=IDLE, timeout<=1, cnt holds at MAX.
  - Otherwise cnt<=cnt+1.
- Period arithmetic: a signal with period N cycles (N<=MAX) gives period=N. A high phase of H cycles gives high_time=H.
- valid is high for exactly one cycle per captured period, and 0 on all other cycles.
- timeout:
  - Stays 1 until the next valid, clear or reset.
  - period and high_time keep their last values on timeout.
- clear=1:
  - Next edge: state=IDLE; period, high_time, cnt, hcap = 0; valid=0; timeout=0.
  - Synchroniser history is kept.
  - clear overrides a simultaneous rise: no capture and no arming that cycle.
- Reset mid-measurement: immediate return to the reset values. The first rise after reset only arms the block.
- Glitches narrower than one clk_in period may be missed. No filtering is required.
- Outputs are registered; no combinational path from sig_in to any output.

Test Plan:
- Clock: toggle clk_in every 1 ns. Hold reset=1 for 100 ns, then release.
- Steady waveform: sig_in period 10 cycles, high 3 cycles, run 5 periods -> first valid at the second rise with period=10, high_time=3. One valid every 10 cycles afterwards, valid width 1 cycle, timeout=0, busy=1.
- Arming only: single rise after reset, then sig_in held high for 20 cycles -> no valid, busy=1. With WIDTH=8 and sig_in held, timeout=1 at cnt=255, then busy=0 and period/high_time unchanged.
- Timeout recovery (WIDTH=8): after timeout, apply 2 rises 40 cycles apart, high 20 -> first rise arms with timeout still 1. Second rise gives valid with period=40, high_time=20, timeout=0.
- Clear collision: assert clear on the cycle rise is detected in MEASURE -> no valid, period=0, high_time=0, state IDLE. The next two rises 7 cycles apart give period=7.
- Async reset mid-period: assert reset 4 cycles after a rise, between clock edges -> all outputs are 0 immediately, before the next edge. After release, the first rise gives no valid, and the second rise reports the correct period (e.g. 12).
- Extremes: period=2 with high=1 -> period=2, high_time=1. Period=MAX (WIDTH=8: 255) -> period=255, no timeout.
